lutram_stress_driver: RTL and testbench
=======================================

# lutram_stress_driver

Self-checking traffic generator for the 16-deep distributed-RAM stress test: it owns the write/address side of the LUTRAM port and consumes its asynchronous read data. Each run writes a deterministic pattern to every address, reads it back, compares, and repeats for a programmable number of passes with alternating polarity. It sits between the test top-level control (start/status) and the LUTRAM under test. Many instances are tiled in the stress design.

## Interface
Parameters:
- DW, 10: data width of the memory word.
- AW, 4: address width; depth = 2**AW.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  run request; sampled only in IDLE.
- seed  in  DW  pattern base; sampled when start is accepted.
- npass  in  8  pass count; sampled when start is accepted; 0 treated as 1.
- busy  out  1  high in WRITE/READ states.
- done  out  1  one-cycle pulse at run end.
- pass_ok  out  1  run result, valid from done until next start.
- err_cnt  out  16  mismatch count for the run, saturating.
- first_err_addr  out  AW  address of first mismatch; 0 if none.
- mem_wdat  out  DW  write data to LUTRAM.
- mem_addr  out  AW  address to LUTRAM (write and read).
- mem_we  out  1  write enable to LUTRAM.
- mem_rdat  in  DW  combinational read data of LUTRAM at mem_addr.

## Operation
- Pattern: base = (seed_q + addr) mod 2**DW, addr zero-extended; even pass (pass_cnt[0]=0) uses base, odd pass uses ~base.
- FSM states IDLE, WRITE, READ, DONE.
- IDLE: mem_we=0, mem_addr=0. start=1 -> capture seed_q, npass_q (0 -> 1), clear err_cnt, first_err_addr, pass_ok, err_seen, pass_cnt=0, addr=0; go WRITE.
- WRITE: mem_we=1, mem_addr=addr, mem_wdat=pattern(addr,pass_cnt); addr increments; at addr=2**AW-1 wrap to 0 and go READ.
- READ: mem_we=0, mem_addr=addr; compare mem_rdat vs pattern in same cycle. Mismatch -> err_cnt+1 (hold at 16'hFFFF); if first mismatch of run, first_err_addr=addr. At last address: if pass_cnt=npass_q-1 go DONE else pass_cnt+1, addr=0, go WRITE.
- DONE: done=1, busy=0, pass_ok=(err_cnt==0 after final compare); next cycle IDLE.
- start while busy or in DONE ignored; seed/npass changes during run ignored.
- mem_wdat is don't-care when mem_we=0; drive pattern anyway (no X).

## Timing
- Reset values: busy=0, done=0, pass_ok=0, err_cnt=0, first_err_addr=0, mem_we=0, mem_addr=0, mem_wdat=0; state IDLE.
- rst mid-run: next cycle all outputs at reset values, mem_we=0 immediately after the edge; run abandoned, no done.
- start sampled high at edge 0 -> WRITE cycles 1..16, READ 17..32 per pass; done high in cycle 32·N+1 for N passes; IDLE at 32·N+2; new start accepted from that cycle.
- All outputs registered except mem_wdat/mem_addr/mem_we, which decode from registered state and addr only (no combinational path from mem_rdat to memory inputs).
- err_cnt/first_err_addr update the edge after the mismatching READ cycle.

## Structure
- Package lutram_stress_pkg: state enum typedef (IDLE, WRITE, READ, DONE), pattern function (seed, addr, pass parity), ERR_CNT_W=16 constant.
- No sub-module inside the driver; the stress top pairs each driver with one LUTRAM instance.

## Test plan
- Clean memory model, seed=0x000, npass=1, start at edge 0 -> writes 0x000..0x00F at addr 0..15, done in cycle 33, pass_ok=1, err_cnt=0.
- Clean memory, seed=0x3F8, npass=2 -> pass 1 writes 0x3F8..0x3FF,0x000..0x007; pass 2 writes complements; done in cycle 65, pass_ok=1.
- Memory with addr 5 bit 0 stuck at 1, seed=0, npass=1 -> pass_ok=1; npass=2 -> err_cnt=1, first_err_addr=5, pass_ok=0.
- Memory returning 0x000 always, seed=0x001, npass=255 -> err_cnt=4080 (16 per pass ×255 passes; no saturation), first_err_addr=0; and npass=0 behaves as npass=1 (done at cycle 33).
- start pulsed again at cycles 5 and 33 of a 1-pass run -> ignored; done only once at 33; start at 34 accepted.
- rst asserted in cycle 20 (READ) -> cycle 21: mem_we=0, busy=0, err_cnt=0, no done pulse; fresh start completes normally.

Source files
------------

// File: rtl/lutram_stress_pkg.sv
// ============================================================================
// Module  : lutram_stress_pkg
// Brief   : Shared types and pattern helper for the LUTRAM stress driver.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lutram_stress_pkg;

    localparam int ERR_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Computed at 32 bits; callers keep the low DW bits, which equals the sum mod 2**DW.
    function automatic logic [31:0] pattern_word(
        input logic [31:0] seed,
        input logic [31:0] addr,
        input logic        odd_pass
    );
        logic [31:0] base;
        base = seed + addr;
        return odd_pass ? ~base : base;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lutram_stress_driver.sv
// ============================================================================
// Module  : lutram_stress_driver
// Brief   : Write/read-back/compare traffic generator for one 2**AW-deep LUTRAM.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module lutram_stress_driver
    import lutram_stress_pkg::*;
#(
    parameter int DW = 10,
    parameter int AW = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [DW-1:0]        seed,
    input  logic [7:0]           npass,
    output logic                 busy,
    output logic                 done,
    output logic                 pass_ok,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [AW-1:0]        first_err_addr,
    output logic [DW-1:0]        mem_wdat,
    output logic [AW-1:0]        mem_addr,
    output logic                 mem_we,
    input  logic [DW-1:0]        mem_rdat
);

    state_e                 state_q,     state_d;
    logic [AW-1:0]          addr_q,      addr_d;
    logic [7:0]             pass_cnt_q,  pass_cnt_d;
    logic [7:0]             npass_q,     npass_d;
    logic [DW-1:0]          seed_q,      seed_d;
    logic [ERR_CNT_W-1:0]   err_cnt_q,   err_cnt_d;
    logic [AW-1:0]          first_err_q, first_err_d;
    logic                   err_seen_q,  err_seen_d;
    logic                   pass_ok_q,   pass_ok_d;
    logic                   busy_q,      busy_d;
    logic                   done_q,      done_d;

    logic [DW-1:0]          w_pat;
    logic                   w_last_addr;
    logic                   w_mismatch;

    assign w_pat       = DW'(pattern_word(32'(seed_q), 32'(addr_q), pass_cnt_q[0]));
    assign w_last_addr = (addr_q == {AW{1'b1}});
    assign w_mismatch  = (mem_rdat != w_pat);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        pass_cnt_d  = pass_cnt_q;
        npass_d     = npass_q;
        seed_d      = seed_q;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_seen_d  = err_seen_q;
        pass_ok_d   = pass_ok_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seed_d      = seed;
                    npass_d     = (npass == 8'd0) ? 8'd1 : npass;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    err_seen_d  = 1'b0;
                    pass_ok_d   = 1'b0;
                    pass_cnt_d  = 8'd0;
                    addr_d      = '0;
                    state_d     = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d = addr_q + AW'(1);
                if (w_last_addr) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                if (w_mismatch) begin
                    if (err_cnt_q != {ERR_CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
                    end
                    if (!err_seen_q) begin
                        first_err_d = addr_q;
                        err_seen_d  = 1'b1;
                    end
                end
                addr_d = addr_q + AW'(1);
                if (w_last_addr) begin
                    if (pass_cnt_q == (npass_q - 8'd1)) begin
                        // Result includes the compare made in this very cycle.
                        pass_ok_d = (err_cnt_d == '0);
                        state_d   = ST_DONE;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 8'd1;
                        state_d    = ST_WRITE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_WRITE) || (state_d == ST_READ);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            pass_cnt_q  <= 8'd0;
            npass_q     <= 8'd1;
            seed_q      <= '0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_seen_q  <= 1'b0;
            pass_ok_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            pass_cnt_q  <= pass_cnt_d;
            npass_q     <= npass_d;
            seed_q      <= seed_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_seen_q  <= err_seen_d;
            pass_ok_q   <= pass_ok_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Memory-side outputs decode only registered state, never mem_rdat.
    assign mem_we         = (state_q == ST_WRITE);
    assign mem_addr       = addr_q;
    assign mem_wdat       = w_pat;

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass_ok        = pass_ok_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

`default_nettype wire

// File: tb/tb_lutram_stress_driver.sv
// ============================================================================
// Module  : tb_lutram_stress_driver
// Brief   : Self-checking bench: LUTRAM model with fault modes plus run-level reference.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lutram_stress_driver;

    localparam int DW    = 10;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [DW-1:0] seed;
    logic [7:0]    npass;
    logic          busy, done, pass_ok, mem_we;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr, mem_addr;
    logic [DW-1:0] mem_wdat, mem_rdat;

    int checks = 0;
    int errors = 0;
    int mode   = 0;   // 0 clean, 1 addr5 bit0 stuck-at-1, 2 always reads zero

    logic [DW-1:0] mem [DEPTH];

    always #5 clk = ~clk;

    lutram_stress_driver #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .npass(npass),
        .busy(busy), .done(done), .pass_ok(pass_ok), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .mem_wdat(mem_wdat),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_rdat(mem_rdat)
    );

    function automatic logic [DW-1:0] fault(input logic [DW-1:0] v, input int a, input int m);
        if (m == 1) return (a == 5) ? (v | 10'd1) : v;
        if (m == 2) return '0;
        return v;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [DW-1:0] s, input int a, input int p);
        logic [DW-1:0] b;
        b = s + DW'(a);
        return (p % 2 == 1) ? ~b : b;
    endfunction

    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdat;
    assign mem_rdat = fault(mem[mem_addr], int'(mem_addr), mode);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Run-level reference: cycle t of a run (1-based) identifies pass, phase and address.
    bit            chk_en = 1'b0;
    bit            m_active, m_seen, m_passok, m_fresh;
    int            m_t, m_n, m_err, m_first;
    logic [DW-1:0] m_seed;
    logic [DW-1:0] shadow [DEPTH];

    always @(posedge clk) begin
        int p, off, a;
        if (rst) begin
            chk_en = 1'b1; m_active = 1'b0; m_t = 0; m_err = 0; m_first = 0;
            m_seen = 1'b0; m_passok = 1'b0; m_seed = '0; m_fresh = 1'b1;
        end else if (m_active) begin
            if (m_t <= 32 * m_n) begin
                p = (m_t - 1) / 32; off = (m_t - 1) % 32; a = off % 16;
                if (off < 16) begin
                    shadow[a] = pat(m_seed, a, p);
                end else begin
                    if (fault(shadow[a], a, mode) != pat(m_seed, a, p)) begin
                        if (m_err < 65535) m_err++;
                        if (!m_seen) begin m_seen = 1'b1; m_first = a; end
                    end
                    if (m_t == 32 * m_n) m_passok = (m_err == 0);
                end
                m_t++;
            end else begin
                m_active = 1'b0; m_t = 0;
            end
        end else if (start) begin
            m_active = 1'b1; m_t = 1; m_seed = seed; m_n = (npass == 0) ? 1 : int'(npass);
            m_err = 0; m_first = 0; m_seen = 1'b0; m_passok = 1'b0; m_fresh = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit e_busy, e_done, e_we;
        int e_addr;
        if (chk_en) begin
            e_busy = m_active && (m_t <= 32 * m_n);
            e_done = m_active && (m_t == 32 * m_n + 1);
            e_we   = e_busy && (((m_t - 1) % 32) < 16);
            e_addr = e_busy ? (m_t - 1) % 16 : 0;
            check("busy", busy, e_busy);
            check("done", done, e_done);
            check("mem_we", mem_we, e_we);
            check("mem_addr", mem_addr, e_addr);
            if (e_we) check("mem_wdat", mem_wdat, pat(m_seed, e_addr, (m_t - 1) / 32));
            else if (m_fresh) check("mem_wdat_rst", mem_wdat, 0);
            check("err_cnt", err_cnt, m_err);
            check("first_err_addr", first_err_addr, m_first);
            check("pass_ok", pass_ok, m_passok);
        end
    end

    // Start a run, scramble seed/npass mid-run, return done cycle and sampled write data.
    task automatic run(input logic [DW-1:0] s, input logic [7:0] n,
                       output int dcyc, output logic [DW-1:0] w16, output logic [DW-1:0] w33);
        int c;
        seed = s; npass = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; seed = ~s; npass = 8'd7;
        dcyc = -1; w16 = '0; w33 = '0;
        for (c = 1; c < 20000; c++) begin
            @(negedge clk);
            if (c == 16) w16 = mem_wdat;
            if (c == 33) w33 = mem_wdat;
            if (done) begin dcyc = c; break; end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int dc, ndone, first_done;
        logic [DW-1:0] w16, w33;
        rst = 1'b1; start = 1'b0; seed = '0; npass = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_wdat", mem_wdat, 0);
        rst = 1'b0;

        mode = 0;
        run(10'h000, 8'd1, dc, w16, w33);
        check("t1_done_cycle", dc, 33);
        check("t1_wdat_addr15", w16, 10'h00F);
        check("t1_pass_ok", pass_ok, 1);
        check("t1_err_cnt", err_cnt, 0);

        run(10'h3F8, 8'd2, dc, w16, w33);
        check("t2_done_cycle", dc, 65);
        check("t2_wdat_p1_addr15", w16, 10'h007);
        check("t2_wdat_p2_addr0", w33, 10'h007);
        check("t2_pass_ok", pass_ok, 1);

        mode = 1;
        run(10'h000, 8'd1, dc, w16, w33);
        check("t3a_pass_ok", pass_ok, 1);
        check("t3a_err_cnt", err_cnt, 0);
        run(10'h000, 8'd2, dc, w16, w33);
        check("t3b_err_cnt", err_cnt, 1);
        check("t3b_first_err", first_err_addr, 5);
        check("t3b_pass_ok", pass_ok, 0);

        mode = 2;
        run(10'h001, 8'd255, dc, w16, w33);
        check("t4a_done_cycle", dc, 8161);
        check("t4a_err_cnt", err_cnt, 4080);
        check("t4a_first_err", first_err_addr, 0);
        check("t4a_pass_ok", pass_ok, 0);
        run(10'h001, 8'd0, dc, w16, w33);
        check("t4b_done_cycle", dc, 33);
        check("t4b_err_cnt", err_cnt, 16);

        // Extra start pulses in cycles 5 and 33 are ignored; the one in 34 starts a new run.
        mode = 0;
        seed = 10'h155; npass = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; first_done = -1;
        for (int c = 1; c <= 70; c++) begin
            @(negedge clk);
            if (done) begin ndone++; if (first_done < 0) first_done = c; end
            if (c == 34) check("t5_done_count_first_run", ndone, 1);
            if (c == 35) check("t5_busy_restart", busy, 1);
            start = (c == 5 || c == 33 || c == 34);
        end
        check("t5_first_done", first_done, 33);
        check("t5_done_count_total", ndone, 2);
        @(posedge clk); #1;

        // Reset in the middle of the READ phase abandons the run.
        mode = 2;
        seed = 10'h0AA; npass = 8'd1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done) ndone++;
            if (c == 20) begin check("t6_err_before_rst", err_cnt, 3); rst = 1'b1; end
            if (c == 21) begin
                check("t6_we_after_rst", mem_we, 0);
                check("t6_busy_after_rst", busy, 0);
                check("t6_err_after_rst", err_cnt, 0);
                rst = 1'b0;
            end
        end
        check("t6_no_done", ndone, 0);
        @(posedge clk); #1;
        mode = 0;
        run(10'h0AA, 8'd1, dc, w16, w33);
        check("t6_fresh_done_cycle", dc, 33);
        check("t6_fresh_pass_ok", pass_ok, 1);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
